fma_16: RTL and testbench

Half-precision (IEEE 754 binary16) fused multiply-add block computing ±(x·y) ± z with a single rounding. It sits in the FP execution path as a zero-latency datapath. Result and per-operation exception flags appear combinationally. A clocked sticky register accumulates flags across operations.

---
 rtl/fma16_pkg.sv | 41 ++++
 rtl/fma16_round.sv | 53 +++++
 rtl/fma_16.sv | 126 ++++++++++++
 tb/tb_fma_16.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fma16_pkg.sv
// Shared types and constants for the binary16 fused multiply-add datapath.
// The exact sum is carried as an unsigned fixed-point magnitude whose LSB weighs 2^-48.
package fma16_pkg;

    typedef enum logic [1:0] {
        RZ  = 2'b00,
        RNE = 2'b01,
        RM  = 2'b10,
        RP  = 2'b11
    } rmode_e;

    localparam int INV = 3;
    localparam int OVF = 2;
    localparam int UNF = 1;
    localparam int NX  = 0;

    localparam int          BIAS   = 15;
    localparam logic [15:0] QNAN   = 16'h7e00;
    localparam logic [15:0] MAXFIN = 16'h7bff;
    localparam logic [15:0] INF    = 16'h7c00;

    // 2^-48 (smallest product LSB) up to just under 2^34 (largest sum, incl. inf/NaN exponents)
    localparam int ACC_W = 82;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] man;
    } half_t;

    function automatic logic round_up(input logic sign, input logic lsb, input logic rnd,
                                      input logic stk, input rmode_e mode);
        case (mode)
            RNE:     return rnd & (stk | lsb);
            RM:      return sign & (rnd | stk);
            RP:      return !sign & (rnd | stk);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fma16_round.sv
// Normalise, round and pack a nonzero exact magnitude into binary16.
// Tininess is judged on the value rounded to 11 bits with an unbounded exponent.
module fma16_round
    import fma16_pkg::*;
(
    input  logic             sign_i,
    input  logic [ACC_W-1:0] mag_i,
    input  rmode_e           mode_i,
    output logic [15:0]      res_o,
    output logic [2:0]       flags_o
);

    localparam logic [ACC_W-1:0] ONE = ACC_W'(1);

    logic [6:0]       msb;
    logic [6:0]       lsb_pos;
    logic [ACC_W-1:0] rmask;
    logic [10:0]      keep;
    logic [5:0]       ebase;
    logic [16:0]      packed_mag;
    logic             rnd, stk, up, nx, ovf, tiny, carry_u, to_inf;

    always_comb begin
        msb = 7'd0;
        for (int i = 0; i < ACC_W; i++)
            if (mag_i[i]) msb = 7'(i);

        // Results below 2^-14 share the subnormal grid, whose LSB sits at bit 24
        lsb_pos = (msb < 7'd34) ? 7'd24 : msb - 7'd10;
        keep    = 11'(mag_i >> lsb_pos);
        rnd     = mag_i[lsb_pos - 7'd1];
        rmask   = (ONE << (lsb_pos - 7'd1)) - ONE;
        stk     = |(mag_i & rmask);
        up      = round_up(sign_i, keep[0], rnd, stk, mode_i);
        ebase   = 6'(lsb_pos - 7'd24);

        // Hidden bit and rounding carry ripple straight into the exponent field
        packed_mag = {1'b0, ebase, 10'b0} + {6'b0, keep} + {16'b0, up};
        ovf        = packed_mag >= 17'h07c00;
        nx         = rnd | stk | ovf;

        carry_u = (&mag_i[33:23]) & round_up(sign_i, 1'b1, mag_i[22], |mag_i[21:0], mode_i);
        tiny    = (msb < 7'd34) & !((msb == 7'd33) & carry_u);

        to_inf = (mode_i == RNE) | ((mode_i == RP) & !sign_i) | ((mode_i == RM) & sign_i);
        if (ovf)
            res_o = {sign_i, to_inf ? INF[14:0] : MAXFIN[14:0]};
        else
            res_o = {sign_i, packed_mag[14:0]};
        flags_o = {ovf, tiny & nx & !ovf, nx};
    end

endmodule

// File: rtl/fma_16.sv
// Binary16 fused multiply-add, +-(x*y) +- z with a single rounding; combinational result
// and flags, plus a registered sticky accumulation of the flags.
module fma_16
    import fma16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    input  logic        mul,
    input  logic        add,
    input  logic        negp,
    input  logic        negz,
    input  logic [1:0]  roundmode,
    output logic [15:0] result,
    output logic [3:0]  flags,
    output logic [3:0]  sticky_flags
);

    half_t [2:0]       op;
    logic  [2:0]       is_nan, is_snan, is_inf, is_zero;
    logic  [2:0][10:0] sig;
    logic  [2:0][4:0]  eeff;
    rmode_e            mode;

    assign op[0] = x;
    assign op[1] = mul ? y : 16'h3c00;
    assign op[2] = add ? z : 16'h0000;
    assign mode  = rmode_e'(roundmode);

    always_comb begin
        is_nan  = '0;
        is_snan = '0;
        is_inf  = '0;
        is_zero = '0;
        sig     = '0;
        eeff    = '0;
        for (int i = 0; i < 3; i++) begin
            is_nan[i]  = (&op[i].exp) & (|op[i].man);
            is_snan[i] = is_nan[i] & !op[i].man[9];
            is_inf[i]  = (&op[i].exp) & !(|op[i].man);
            is_zero[i] = (op[i].exp == 5'd0) & !(|op[i].man);
            sig[i]     = {|op[i].exp, op[i].man};
            eeff[i]    = (op[i].exp == 5'd0) ? 5'd1 : op[i].exp;
        end
    end

    logic [21:0]      prod;
    logic [5:0]       pshift, zshift;
    logic [ACC_W-1:0] pacc, zacc, sum;
    logic             psgn, zsgn, ssgn;

    // Place both terms on the common 2^-48 grid: product LSB at exp_x+exp_y-2, addend at exp_z+23
    assign prod   = 22'(sig[0]) * 22'(sig[1]);
    assign pshift = 6'(eeff[0]) + 6'(eeff[1]) - 6'd2;
    assign zshift = 6'(eeff[2]) + 6'd23;
    assign pacc   = ACC_W'(prod) << pshift;
    assign zacc   = ACC_W'(sig[2]) << zshift;
    assign psgn   = op[0].sign ^ op[1].sign ^ negp;
    assign zsgn   = op[2].sign ^ negz;

    always_comb begin
        if (psgn == zsgn) begin
            sum  = pacc + zacc;
            ssgn = psgn;
        end else if (pacc >= zacc) begin
            sum  = pacc - zacc;
            ssgn = psgn;
        end else begin
            sum  = zacc - pacc;
            ssgn = zsgn;
        end
    end

    logic [15:0] rnd_res;
    logic [2:0]  rnd_flags;

    fma16_round u_round (
        .sign_i  (ssgn),
        .mag_i   (sum),
        .mode_i  (mode),
        .res_o   (rnd_res),
        .flags_o (rnd_flags)
    );

    logic prod_inf, invalid, zero_sgn;

    assign prod_inf = is_inf[0] | is_inf[1];
    assign invalid  = (is_inf[0] & is_zero[1]) | (is_zero[0] & is_inf[1]) |
                      (prod_inf & is_inf[2] & (psgn != zsgn));
    assign zero_sgn = ((is_zero[0] | is_zero[1]) & is_zero[2] & (psgn == zsgn)) ? psgn
                                                                                : (mode == RM);

    always_comb begin
        result = rnd_res;
        flags  = {1'b0, rnd_flags};
        if (|is_nan) begin
            result = QNAN;
            flags  = {|is_snan, 3'b000};
        end else if (invalid) begin
            result = QNAN;
            flags  = 4'b1000;
        end else if (prod_inf) begin
            result = {psgn, INF[14:0]};
            flags  = 4'b0000;
        end else if (is_inf[2]) begin
            result = {zsgn, INF[14:0]};
            flags  = 4'b0000;
        end else if (sum == '0) begin
            result = {zero_sgn, 15'd0};
            flags  = 4'b0000;
        end
    end

    logic [3:0] sticky_q, sticky_d;

    assign sticky_d     = sticky_q | flags;
    assign sticky_flags = sticky_q;

    always_ff @(posedge clk) begin
        if (reset) sticky_q <= 4'b0000;
        else       sticky_q <= sticky_d;
    end

endmodule

// File: tb/tb_fma_16.sv
// Bench for fma_16: a value-level reference model checked every cycle, plus
// hand-computed vectors for the headline cases and the sticky register.
module tb_fma_16;

    localparam logic [1:0] M_RZ = 2'b00, M_RNE = 2'b01, M_RM = 2'b10, M_RP = 2'b11;
    localparam logic [127:0] T34 = 128'd1 << 34;
    localparam logic [127:0] T23 = 128'd1 << 23;
    localparam logic [127:0] T22 = 128'd1 << 22;

    logic        clk = 1'b0, reset = 1'b1;
    logic [15:0] x = 16'h0, y = 16'h0, z = 16'h0;
    logic        mul = 1'b0, add = 1'b0, negp = 1'b0, negz = 1'b0;
    logic [1:0]  roundmode = M_RNE;
    logic [15:0] result;
    logic [3:0]  flags, sticky_flags;

    int          n_tests = 0, n_fail = 0;
    logic        st_valid = 1'b0;
    logic [3:0]  st_exp = 4'b0, last_mf = 4'b0;
    logic [15:0] mr;
    logic [3:0]  mf;

    fma_16 dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .z            (z),
        .mul          (mul),
        .add          (add),
        .negp         (negp),
        .negz         (negz),
        .roundmode    (roundmode),
        .result       (result),
        .flags        (flags),
        .sticky_flags (sticky_flags)
    );

    always #5 clk = ~clk;

    function automatic logic isnan(input logic [15:0] h);
        return (h[14:10] == 5'h1f) && (h[9:0] != 10'd0);
    endfunction
    function automatic logic issnan(input logic [15:0] h);
        return isnan(h) && !h[9];
    endfunction
    function automatic logic isinf(input logic [15:0] h);
        return h[14:0] == 15'h7c00;
    endfunction
    function automatic logic iszero(input logic [15:0] h);
        return h[14:0] == 15'h0000;
    endfunction

    // |h| scaled by 2^24 (exact integer for every finite binary16; 7c00 gives 2^16)
    function automatic logic [127:0] v24(input logic [15:0] h);
        if (h[14:10] == 5'd0) return {118'd0, h[9:0]};
        return {117'd0, 1'b1, h[9:0]} << (h[14:10] - 5'd1);
    endfunction
    function automatic logic [127:0] val48(input logic [15:0] h);
        return v24(h) << 24;
    endfunction

    // Exact value on a 2^-48 grid, then pick the bracketing binary16 encodings by search.
    function automatic void model(input logic [15:0] xi, input logic [15:0] yi, input logic [15:0] zi,
                                  input logic mi, input logic ai, input logic np, input logic nz,
                                  input logic [1:0] rm, output logic [15:0] r, output logic [3:0] f);
        logic [15:0] yv, zv;
        logic ps, zs, s, nx, up, tup, tiny;
        logic [127:0] pm, zm, a, lv, hv;
        logic signed [127:0] ex;
        int lo, hi, mid;
        yv = mi ? yi : 16'h3c00;
        zv = ai ? zi : 16'h0000;
        ps = xi[15] ^ yv[15] ^ np;
        zs = zv[15] ^ nz;
        r  = 16'h7e00;
        f  = 4'b0000;
        if (isnan(xi) || isnan(yv) || isnan(zv)) begin
            f[3] = issnan(xi) || issnan(yv) || issnan(zv);
            return;
        end
        if ((isinf(xi) && iszero(yv)) || (iszero(xi) && isinf(yv)) ||
            ((isinf(xi) || isinf(yv)) && isinf(zv) && ps != zs)) begin
            f = 4'b1000;
            return;
        end
        if (isinf(xi) || isinf(yv)) begin r = {ps, 15'h7c00}; return; end
        if (isinf(zv)) begin r = {zs, 15'h7c00}; return; end
        pm = v24(xi) * v24(yv);
        zm = val48(zv);
        ex = (ps ? -$signed(pm) : $signed(pm)) + (zs ? -$signed(zm) : $signed(zm));
        if (ex == 0) begin
            s = ((iszero(xi) || iszero(yv)) && iszero(zv) && ps == zs) ? ps : (rm == M_RM);
            r = {s, 15'd0};
            return;
        end
        s = ex < 0;
        a = s ? 128'(-ex) : 128'(ex);
        if (a < val48(16'h7c00)) begin
            lo = 0;
            hi = 32'h7bff;
            while (lo < hi) begin
                mid = (lo + hi + 1) / 2;
                if (val48(16'(mid)) <= a) lo = mid;
                else hi = mid - 1;
            end
            lv = val48(16'(lo));
            hv = val48(16'(lo + 1));
            nx = a != lv;
            case (rm)
                M_RZ:    up = 1'b0;
                M_RNE:   up = (2 * a > lv + hv) || ((2 * a == lv + hv) && lo[0]);
                M_RM:    up = nx && s;
                default: up = nx && !s;
            endcase
            if (!(up && lo == 32'h7bff)) begin
                case (rm)
                    M_RZ:    tup = 1'b0;
                    M_RNE:   tup = a >= T34 - T23 + T22;
                    M_RM:    tup = s;
                    default: tup = !s;
                endcase
                tiny = (a < T34) && !((a > T34 - T23) && tup);
                r = {s, 15'(up ? lo + 1 : lo)};
                f = {2'b00, nx && tiny, nx};
                return;
            end
        end
        r = {s, (rm == M_RNE || (rm == M_RP && !s) || (rm == M_RM && s)) ? 15'h7c00 : 15'h7bff};
        f = 4'b0101;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        model(x, y, z, mul, add, negp, negz, roundmode, mr, mf);
        chk("model result", result, mr);
        chk("model flags", {12'd0, flags}, {12'd0, mf});
        if (st_valid) chk("model sticky", {12'd0, sticky_flags}, {12'd0, st_exp});
        last_mf = mf;
    end

    always @(posedge clk) begin
        if (reset) begin
            st_exp   = 4'b0000;
            st_valid = 1'b1;
        end else begin
            st_exp = st_exp | last_mf;
        end
    end

    task automatic apply(input logic [15:0] xi, input logic [15:0] yi, input logic [15:0] zi,
                         input logic mi, input logic ai, input logic np, input logic nz,
                         input logic [1:0] rm);
        @(posedge clk);
        #1;
        x = xi; y = yi; z = zi;
        mul = mi; add = ai; negp = np; negz = nz; roundmode = rm;
        @(negedge clk);
        #1;
    endtask

    task automatic vec(input string name, input logic [15:0] xi, input logic [15:0] yi,
                       input logic [15:0] zi, input logic mi, input logic ai, input logic np,
                       input logic nz, input logic [1:0] rm, input logic [15:0] er,
                       input logic [3:0] ef);
        apply(xi, yi, zi, mi, ai, np, nz, rm);
        chk({name, " result"}, result, er);
        chk({name, " flags"}, {12'd0, flags}, {12'd0, ef});
    endtask

    initial begin
        logic [15:0] rx, ry, rz;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        vec("one_x_one",   16'h3c00, 16'h3c00, 16'h0000, 1, 0, 0, 0, M_RNE, 16'h3c00, 4'b0000);
        vec("two_x_three", 16'h4000, 16'h4200, 16'h0000, 1, 0, 0, 0, M_RNE, 16'h4600, 4'b0000);
        vec("fma_1_1_1",   16'h3c00, 16'h3c00, 16'h3c00, 1, 1, 0, 0, M_RNE, 16'h4000, 4'b0000);
        vec("cancel_rne",  16'h3c00, 16'h3c00, 16'h3c00, 1, 1, 0, 1, M_RNE, 16'h0000, 4'b0000);
        vec("cancel_rm",   16'h3c00, 16'h3c00, 16'h3c00, 1, 1, 0, 1, M_RM,  16'h8000, 4'b0000);
        vec("ovf_rne",     16'h7bff, 16'h4000, 16'h0000, 1, 0, 0, 0, M_RNE, 16'h7c00, 4'b0101);
        vec("ovf_rz",      16'h7bff, 16'h4000, 16'h0000, 1, 0, 0, 0, M_RZ,  16'h7bff, 4'b0101);
        vec("ovf_rm_neg",  16'h7bff, 16'h4000, 16'h0000, 1, 0, 1, 0, M_RM,  16'hfc00, 4'b0101);
        vec("inf_x_zero",  16'h7c00, 16'h0000, 16'h0000, 1, 0, 0, 0, M_RNE, 16'h7e00, 4'b1000);
        vec("subn_half",   16'h0001, 16'h3800, 16'h0000, 1, 0, 0, 0, M_RNE, 16'h0000, 4'b0011);
        vec("tiny_edge",   16'h07ff, 16'h3800, 16'h0000, 1, 0, 0, 0, M_RNE, 16'h0400, 4'b0011);
        vec("min_rp",      16'h0001, 16'h0001, 16'h0000, 1, 0, 0, 0, M_RP,  16'h0001, 4'b0011);

        // Model-checked directed corners
        for (int m = 0; m < 4; m++) begin
            apply(16'h3555, 16'h3555, 16'h0000, 1, 0, 0, 0, 2'(m));
            apply(16'h3555, 16'h3555, 16'h3c00, 1, 1, 1, 0, 2'(m));
            apply(16'h0001, 16'h0001, 16'h0000, 1, 0, 1, 0, 2'(m));
            apply(16'h7bff, 16'h3c00, 16'h4c00, 1, 1, 0, 0, 2'(m));
            apply(16'h7bff, 16'h3c00, 16'h4c00, 1, 1, 1, 1, 2'(m));
            apply(16'h3c01, 16'h3c01, 16'h3c02, 1, 1, 0, 1, 2'(m));
            apply(16'h8000, 16'h0000, 16'h8000, 1, 1, 0, 0, 2'(m));
            apply(16'h8000, 16'h3c00, 16'h0000, 1, 0, 0, 0, 2'(m));
            apply(16'h07ff, 16'h3800, 16'h0000, 1, 0, 1, 0, 2'(m));
            apply(16'h03ff, 16'h3c00, 16'h0001, 1, 1, 0, 0, 2'(m));
        end
        apply(16'h7c01, 16'h3c00, 16'h0000, 1, 0, 0, 0, M_RNE);
        apply(16'h3c00, 16'h7e00, 16'h0000, 1, 0, 0, 0, M_RNE);
        apply(16'h4500, 16'h7c01, 16'h0000, 0, 0, 0, 0, M_RNE);
        apply(16'h4500, 16'h3c00, 16'h7c01, 1, 0, 0, 0, M_RNE);
        apply(16'h7c00, 16'h3c00, 16'h7c00, 1, 1, 0, 1, M_RNE);
        apply(16'hfc00, 16'h4000, 16'h4000, 1, 1, 0, 0, M_RNE);
        apply(16'h4000, 16'h4000, 16'h7c00, 1, 1, 0, 1, M_RNE);

        for (int i = 0; i < 200; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rz = 16'($urandom);
            if (i % 2 == 1) begin
                rx[14:10] = 5'($urandom_range(8, 22));
                ry[14:10] = 5'($urandom_range(8, 22));
                rz[14:10] = 5'(32'(rx[14:10]) + 32'(ry[14:10]) - 15 + $urandom_range(0, 2));
            end
            apply(rx, ry, rz, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom));
        end

        // Sticky register: clear, accumulate overflow then invalid, then reset beats a flag
        apply(16'h3c00, 16'h3c00, 16'h0000, 1, 0, 0, 0, M_RNE);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); #1;
        chk("sticky after reset", {12'd0, sticky_flags}, 16'h0000);
        vec("ovf_rne_2",  16'h7bff, 16'h4000, 16'h0000, 1, 0, 0, 0, M_RNE, 16'h7c00, 4'b0101);
        vec("invalid_2",  16'h7c00, 16'h0000, 16'h0000, 1, 0, 0, 0, M_RNE, 16'h7e00, 4'b1000);
        apply(16'h3c00, 16'h3c00, 16'h0000, 1, 0, 0, 0, M_RNE);
        chk("sticky accumulated", {12'd0, sticky_flags}, 16'h000d);
        @(posedge clk);
        #1;
        reset = 1'b1;
        x = 16'h7c00; y = 16'h0000; z = 16'h0000; mul = 1'b1; add = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        x = 16'h3c00; y = 16'h3c00;
        @(negedge clk); #1;
        chk("sticky reset wins", {12'd0, sticky_flags}, 16'h0000);

        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
